// File: rtl/drum_pkg.sv
// Shared constants for the drum voice player: voice indices,
// per-voice state encoding and the noise LFSR definition.
package drum_pkg;

  localparam int NUM_VOICES = 5;

  localparam int V_A = 0;
  localparam int V_B = 1;
  localparam int V_C = 2;
  localparam int V_D = 3;
  localparam int V_E = 4;

  typedef enum logic {
    IDLE,
    SOUND
  } voice_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 0,2,3,5 of a right shift
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/drum_voice.sv
// One drum voice: IDLE/SOUND FSM with phase and duration counters.
// Exposes a phase-wrap strobe only when DRUM_NOISE_EN is defined.
module drum_voice
  import drum_pkg::*;
#(
  parameter int CNT_W      = 20,
  parameter int DUR_CYCLES = 200000,
  parameter int HALF       = 50000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic fire,
  input  logic playing,
  output logic sq,
  output logic active
`ifdef DRUM_NOISE_EN
  ,
  output logic wrap
`endif
);

  localparam logic [CNT_W-1:0] DUR_LAST  = CNT_W'(DUR_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

  voice_state_t     state, state_n;
  logic             sq_n;
  logic [CNT_W-1:0] ph, ph_n;
  logic [CNT_W-1:0] dur, dur_n;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      sq    <= 1'b0;
      ph    <= '0;
      dur   <= '0;
    end else begin
      state <= state_n;
      sq    <= sq_n;
      ph    <= ph_n;
      dur   <= dur_n;
    end
  end

  always_comb begin
    state_n = state;
    sq_n    = sq;
    ph_n    = ph;
    dur_n   = dur;
    // A fire restarts the burst even on the cycle it would expire
    if (fire) begin
      state_n = SOUND;
      sq_n    = 1'b1;
      ph_n    = '0;
      dur_n   = DUR_LAST;
    end else if (state == SOUND) begin
      if (!playing || dur == '0) begin
        state_n = IDLE;
        sq_n    = 1'b0;
        ph_n    = '0;
        dur_n   = '0;
      end else begin
        dur_n = dur - 1'b1;
        if (ph == HALF_LAST) begin
          ph_n = '0;
          sq_n = ~sq;
        end else begin
          ph_n = ph + 1'b1;
        end
      end
    end
  end

  assign active = (state == SOUND);

`ifdef DRUM_NOISE_EN
  assign wrap = (state == SOUND) && (ph == HALF_LAST);
`endif

endmodule

// File: rtl/drum_voice_player.sv
// Five-voice drum burst player with 1-bit speaker and 3-bit mix level.
// Define DRUM_NOISE_EN to turn voice E into an LFSR noise voice.
module drum_voice_player
  import drum_pkg::*;
#(
  parameter int CNT_W      = 20,
  parameter int DUR_CYCLES = 200000,
  parameter int HALF_A     = 50000,
  parameter int HALF_B     = 38000,
  parameter int HALF_C     = 25000,
  parameter int HALF_D     = 19000,
  parameter int HALF_E     = 12000
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  CCEN,
  input  logic                  playing,
  input  logic [NUM_VOICES-1:0] trig,
  output logic [NUM_VOICES-1:0] voice_sq,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic                  speaker,
  output logic [2:0]            mix
);

  localparam int HALVES [NUM_VOICES] = '{
    HALF_A, HALF_B, HALF_C, HALF_D, HALF_E
  };

  logic [NUM_VOICES-1:0] fire;
  logic [NUM_VOICES-1:0] sq_raw;
`ifdef DRUM_NOISE_EN
  logic [NUM_VOICES-1:0] wrap;
`endif

  assign fire = {NUM_VOICES{CCEN & playing}} & trig;

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    drum_voice #(
      .CNT_W      (CNT_W),
      .DUR_CYCLES (DUR_CYCLES),
      .HALF       (HALVES[i])
    ) u_voice (
      .Clk     (Clk),
      .Reset   (Reset),
      .fire    (fire[i]),
      .playing (playing),
      .sq      (sq_raw[i]),
      .active  (voice_active[i])
`ifdef DRUM_NOISE_EN
      ,
      .wrap    (wrap[i])
`endif
    );
  end

`ifdef DRUM_NOISE_EN
  logic [15:0] lfsr;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lfsr <= LFSR_SEED;
    end else if (fire[V_E]) begin
      lfsr <= LFSR_SEED;
    end else if (wrap[V_E]) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  assign voice_sq = {voice_active[V_E] & lfsr[0],
                     sq_raw[V_D:V_A]};
`else
  assign voice_sq = sq_raw;
`endif

  assign speaker = |voice_sq;

  always_comb begin
    mix = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      mix = mix + {2'b00, voice_sq[i]};
    end
  end

endmodule

// File: tb/tb_drum_voice_player.sv
// Randomised and directed bench for drum_voice_player with an
// age-based burst model; also covers the DRUM_NOISE_EN build.
module tb_drum_voice_player;

  localparam int DUR = 10;
  localparam int HALF [5] = '{2, 3, 1, 4, 5};

  logic       Clk = 1'b0;
  logic       Reset;
  logic       CCEN;
  logic       playing;
  logic [4:0] trig;
  logic [4:0] voice_sq;
  logic [4:0] voice_active;
  logic       speaker;
  logic [2:0] mix;

  int checks = 0;
  int errors = 0;
  int age [5];
  bit run = 1'b0;

  drum_voice_player #(
    .CNT_W      (8),
    .DUR_CYCLES (DUR),
    .HALF_A     (2),
    .HALF_B     (3),
    .HALF_C     (1),
    .HALF_D     (4),
    .HALF_E     (5)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .CCEN         (CCEN),
    .playing      (playing),
    .trig         (trig),
    .voice_sq     (voice_sq),
    .voice_active (voice_active),
    .speaker      (speaker),
    .mix          (mix)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // age = cycles since the burst started (1 on first sound cycle), 0 = silent
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 5; i++) age[i] = 0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (CCEN && playing && trig[i]) age[i] = 1;
        else if (age[i] > 0) begin
          if (!playing || age[i] >= DUR) age[i] = 0;
          else age[i] = age[i] + 1;
        end
      end
    end
  end

  function automatic bit lfsr_bit(input int steps);
    logic [15:0] l;
    l = 16'hACE1;
    for (int s = 0; s < steps; s++) begin
      l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    end
    return l[0];
  endfunction

  function automatic bit exp_sq(input int i);
    int k;
    if (age[i] == 0) return 1'b0;
    k = (age[i] - 1) / HALF[i];
`ifdef DRUM_NOISE_EN
    if (i == 4) return lfsr_bit(k);
`endif
    return (k % 2) == 0;
  endfunction

  always @(negedge Clk) begin
    logic [4:0] es, ea;
    int em;
    if (run && !Reset) begin
      em = 0;
      for (int i = 0; i < 5; i++) begin
        es[i] = exp_sq(i);
        ea[i] = age[i] > 0;
        em += int'(es[i]);
      end
      chk("model_sq", int'(voice_sq), int'(es));
      chk("model_active", int'(voice_active), int'(ea));
      chk("model_mix", int'(mix), em);
      chk("model_speaker", int'(speaker), int'(es != 0));
    end
  end

  task automatic cyc(input logic c, input logic p, input logic [4:0] t);
    CCEN    = c;
    playing = p;
    trig    = t;
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 5'b0);
  endtask

  int pat [10] = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1};

  initial begin
    Reset = 1'b1;
    CCEN = 1'b0;
    playing = 1'b0;
    trig = '0;
    repeat (2) @(negedge Clk);
    #1 Reset = 1'b0;
    run = 1'b1;
    chk("reset_sq", int'(voice_sq), 0);
    chk("reset_mix", int'(mix), 0);

    // single fire on voice A
    cyc(1'b1, 1'b1, 5'b00001);
    for (int k = 1; k <= 10; k++) begin
      chk("t2_active", int'(voice_active[0]), 1);
      chk("t2_sq", int'(voice_sq[0]), pat[k-1]);
      idle(1);
    end
    chk("t2_end_active", int'(voice_active[0]), 0);
    chk("t2_end_sq", int'(voice_sq[0]), 0);

    // gating
    cyc(1'b1, 1'b0, 5'b11111);
    chk("t3_not_playing", int'(voice_active), 0);
    cyc(1'b0, 1'b1, 5'b11111);
    chk("t3_no_ccen", int'(voice_active), 0);

    // all voices
    cyc(1'b1, 1'b1, 5'b11111);
    chk("t4_mix5", int'(mix), 5);
    chk("t4_speaker", int'(speaker), 1);
    idle(1);
    chk("t4_mix4", int'(mix), 4);
    idle(12);

    // retrigger voice A at cycle 6
    cyc(1'b1, 1'b1, 5'b00001);
    idle(5);
    cyc(1'b1, 1'b1, 5'b00001);
    chk("t5_sq_c7", int'(voice_sq[0]), 1);
    for (int k = 7; k <= 16; k++) begin
      chk("t5_active", int'(voice_active[0]), 1);
      idle(1);
    end
    chk("t5_end", int'(voice_active[0]), 0);
    idle(12);

    // stop voice D mid-burst
    cyc(1'b1, 1'b1, 5'b01000);
    idle(3);
    cyc(1'b0, 1'b0, 5'b0);
    chk("t6_active", int'(voice_active[3]), 0);
    chk("t6_sq", int'(voice_sq[3]), 0);
    idle(12);

`ifdef DRUM_NOISE_EN
    cyc(1'b1, 1'b1, 5'b10000);
    chk("noise_c1", int'(voice_sq[4]), 1);
    idle(4);
    chk("noise_c5", int'(voice_sq[4]), 1);
    idle(1);
    chk("noise_c6", int'(voice_sq[4]), 0);
    cyc(1'b1, 1'b1, 5'b10000);
    chk("noise_refire", int'(voice_sq[4]), 1);
    idle(5);
    chk("noise_refire_c6", int'(voice_sq[4]), 0);
    idle(12);
`endif

    // async reset mid-burst
    cyc(1'b1, 1'b1, 5'b11111);
    idle(3);
    #1 Reset = 1'b1;
    #1;
    chk("t1_sq", int'(voice_sq), 0);
    chk("t1_active", int'(voice_active), 0);
    chk("t1_speaker", int'(speaker), 0);
    chk("t1_mix", int'(mix), 0);
    @(negedge Clk);
    #1 Reset = 1'b0;

    for (int n = 0; n < 600; n++) begin
      cyc(1'b1 && ($urandom % 3 == 0), 1'b1 && ($urandom % 6 != 0),
          5'($urandom));
    end

    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

endmodule
